icache: RTL and testbench

Direct-mapped, read-only instruction cache between the pipelined core's fetch stage (`pc` out, `instr` in) and a word-wide backing instruction memory. A hit returns the instruction combinationally in the same cycle. A miss raises `stall` to freeze fetch and refills one whole line, one word per handshake, then resumes.

---
 rtl/icache.sv | 140 ++++++++++++++
 tb/tb_icache.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache.
// A hit returns the instruction in the same cycle. A miss stalls fetch while
// the whole line is refilled from backing memory, one word per handshake.
module icache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        stall,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 32 - OB - IB - 2;
  localparam int LW = 32 - OB - 2;
  localparam logic [OB-1:0] last_word = OB'(WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state_r;
  logic [LINES-1:0]  valid_r;
  logic [TW-1:0]     tag_r  [LINES];
  logic [31:0]       data_r [LINES*WORDS];
  // Line address of the fill in progress (pc with offset and byte bits dropped).
  logic [LW-1:0]     line_r;
  logic [OB-1:0]     cnt_r;
  logic              mem_req_r;

  logic [OB-1:0]     pc_off_s;
  logic [IB-1:0]     pc_idx_s;
  logic [TW-1:0]     pc_tag_s;
  logic [IB-1:0]     fill_idx_s;
  logic [TW-1:0]     fill_tag_s;
  logic              hit_s;
  logic              fill_beat_s;
  logic              unused_ok_s;

  assign pc_off_s    = pc[OB+1:2];
  assign pc_idx_s    = pc[OB+IB+1:OB+2];
  assign pc_tag_s    = pc[31:OB+IB+2];
  assign fill_idx_s  = line_r[IB-1:0];
  assign fill_tag_s  = line_r[LW-1:IB];
  // A word is accepted only on a handshake that is not being cancelled by inv.
  assign fill_beat_s = (state_r == FILL) && mem_ready && !inv;
  // Byte-select bits of pc play no part in an instruction fetch.
  assign unused_ok_s = &{1'b0, pc[1:0]};

  // Outputs toward memory come straight from registers, so they are stable all cycle.
  assign mem_req  = mem_req_r;
  assign mem_addr = {line_r, cnt_r, 2'b00};
  assign stall    = !hit_s;

  // Hit detection and combinational instruction read (nop on a miss).
  always_comb begin
    hit_s = 1'b0;
    instr = 32'h0000_0000;
    if ((state_r == IDLE) && valid_r[pc_idx_s] && (tag_r[pc_idx_s] == pc_tag_s)) begin
      hit_s = 1'b1;
      instr = data_r[{pc_idx_s, pc_off_s}];
    end else begin
      hit_s = 1'b0;
      instr = 32'h0000_0000;
    end
  end

  // Control FSM: start a fill on a miss, count words, validate on the last one, invalidate on inv.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      valid_r   <= {LINES{1'b0}};
      line_r    <= {LW{1'b0}};
      cnt_r     <= {OB{1'b0}};
      mem_req_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (inv) begin
            valid_r <= {LINES{1'b0}};
          end else if (!hit_s) begin
            line_r    <= pc[31:OB+2];
            cnt_r     <= {OB{1'b0}};
            state_r   <= FILL;
            mem_req_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        FILL: begin
          if (inv) begin
            // Abandon the fill; the partial line never becomes valid.
            valid_r   <= {LINES{1'b0}};
            state_r   <= IDLE;
            mem_req_r <= 1'b0;
          end else if (mem_ready) begin
            cnt_r <= cnt_r + 1'b1;
            if (cnt_r == last_word) begin
              valid_r[fill_idx_s] <= 1'b1;
              state_r             <= IDLE;
              mem_req_r           <= 1'b0;
            end else begin
              state_r <= FILL;
            end
          end else begin
            state_r <= FILL;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Line storage: data words and tag are written during fills only; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_beat_s) begin
      data_r[{fill_idx_s, cnt_r}] <= mem_rdata;
      if (cnt_r == last_word) begin
        tag_r[fill_idx_s] <= fill_tag_s;
      end else begin
        tag_r[fill_idx_s] <= tag_r[fill_idx_s];
      end
    end else begin
      data_r[{fill_idx_s, cnt_r}] <= data_r[{fill_idx_s, cnt_r}];
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches,
// all checked against a line-level model of which lines are resident.
module tb_icache;

  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int OB    = 2;
  localparam int IB    = 4;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        inv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int passed = 0;

  // Reference model: which tag each line holds, if any.
  bit          mvalid [LINES];
  logic [31:0] mtag   [LINES];

  icache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .instr     (instr),
    .stall     (stall),
    .inv       (inv),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // Backing memory contents: word address times 0x11.
  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a >> 2) * 32'h0000_0011;
  endfunction

  // Backing memory answers combinationally from the requested address.
  always_comb mem_rdata = memval(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  // One fetch of address a. mode 0: ready always 1, 1: random ready, 2: ready 0,1,0,1...
  // Returns the number of stalled cycles seen from the bench's own timeline.
  task automatic fetch(input logic [31:0] a, input int mode, output int stalls);
    int          idx;
    logic [31:0] tg;
    logic [31:0] base;
    bit          hit_e;
    int          ones;
    int          fill;
    logic        r;
    idx   = int'((a >> (2 + OB)) % LINES);
    tg    = a >> (2 + OB + IB);
    base  = a & ~32'(WORDS * 4 - 1);
    hit_e = mvalid[idx] && (mtag[idx] == tg);
    pc = a; inv = 1'b0; mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("stall_first", {31'd0, stall}, {31'd0, !hit_e});
    chk("mem_req_idle", {31'd0, mem_req}, 32'd0);
    if (hit_e) begin
      chk("hit_instr", instr, memval(a));
      stalls = 0;
      @(posedge clk); #1;
    end else begin
      chk("miss_instr", instr, 32'h0000_0000);
      @(posedge clk); #1;
      ones = 0;
      fill = 0;
      while (ones < WORDS && fill < 200) begin
        if (mode == 0) r = 1'b1;
        else if (mode == 1) r = ($urandom_range(0, 3) != 0);
        else r = 1'(fill % 2);
        mem_ready = r;
        pc = $urandom;
        @(negedge clk);
        chk("fill_stall", {31'd0, stall}, 32'd1);
        chk("fill_req", {31'd0, mem_req}, 32'd1);
        chk("fill_addr", mem_addr, base + 32'(ones * 4));
        if (r) ones++;
        fill++;
        @(posedge clk); #1;
      end
      pc = a; mem_ready = 1'b0;
      @(negedge clk);
      chk("refill_stall", {31'd0, stall}, 32'd0);
      chk("refill_instr", instr, memval(a));
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      stalls = fill + 1;
      @(posedge clk); #1;
    end
  endtask

  // One-cycle invalidate pulse with pc at a.
  task automatic inv_pulse(input logic [31:0] a);
    int idx;
    idx = int'((a >> (2 + OB)) % LINES);
    pc = a; inv = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("inv_stall", {31'd0, stall}, {31'd0, !(mvalid[idx] && mtag[idx] == (a >> (2 + OB + IB)))});
    @(posedge clk); #1;
    inv = 1'b0;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int refills;
    logic [31:0] a;
    clk = 1'b0; reset = 1'b1; pc = 32'h0; inv = 1'b0; mem_ready = 1'b1;
    model_clear();

    // Reset state
    #3;
    chk("rst_stall", {31'd0, stall}, 32'd1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // First miss at 0: five stalled cycles, then word 0 and a hit at 0x8
    fetch(32'h0000_0000, 0, s);
    chk("first_stalls", s, 32'd5);
    fetch(32'h0000_0008, 0, s);
    chk("hit_08_stalls", s, 32'd0);
    chk("hit_08_val", instr, 32'h0000_0022);

    // Invalidate, then sequential fetch 0x00..0x3C refills four lines
    inv_pulse(32'h0000_0000);
    refills = 0;
    for (int i = 0; i < 16; i++) begin
      fetch(32'(i * 4), 0, s);
      if (s != 0) begin
        refills++;
        chk("seq_stalls", s, 32'd5);
      end
    end
    chk("seq_refills", refills, 32'd4);

    // Conflict on the same index, different tag
    fetch(32'h0000_0110, 0, s);
    chk("conflict_miss", s, 32'd5);
    fetch(32'h0000_0010, 0, s);
    chk("conflict_back", s, 32'd5);

    // Ready alternating 0,1,0,1: eight fill cycles
    fetch(32'h0000_0200, 2, s);
    chk("toggle_stalls", s, 32'd9);

    // inv on the second word of a fill
    pc = 32'h0000_0300; mem_ready = 1'b1; inv = 1'b0;
    @(negedge clk); chk("invf_detect", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("invf_w0", mem_addr, 32'h0000_0300);
    @(posedge clk); #1;
    inv = 1'b1;
    @(negedge clk); chk("invf_w1", mem_addr, 32'h0000_0304);
    @(posedge clk); #1;
    inv = 1'b0;
    model_clear();
    fetch(32'h0000_0300, 0, s);
    chk("invf_refill", s, 32'd5);

    // Reset during the third fill word
    pc = 32'h0000_0400; mem_ready = 1'b1;
    @(negedge clk); chk("rstf_detect", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk); chk("rstf_req", {31'd0, mem_req}, 32'd1);
      @(posedge clk); #1;
    end
    #2; reset = 1'b1; #1;
    chk("rstf_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rstf_addr", mem_addr, 32'h0);
    chk("rstf_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    fetch(32'h0000_0400, 0, s);
    chk("rstf_refill", s, 32'd5);

    // Randomized fetches with random ready and occasional invalidates
    for (int n = 0; n < 150; n++) begin
      a = {21'd0, 11'($urandom)};
      if ($urandom_range(0, 15) == 0) inv_pulse(a);
      else fetch(a, 1, s);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
